// File: rtl/count_chk_pkg.sv
// Shared types and helpers for the count-stream checker.
// Holds the FSM state type, the counter next-value rule and the error saturation constant.
package count_chk_pkg;

  typedef enum logic [1:0] {IDLE, SYNC, TRACK, HALT} chk_state_t;

  localparam int unsigned CNT_MAXW = 32;
  localparam int unsigned ERRW_DEF = 16;
  // Wide all-ones; users cast down to their own error-counter width (up to 64 bits).
  localparam logic [63:0] ERR_SAT  = '1;

  // Counter next-state rule: sync reset beats load, otherwise increment with wrap at 'width'.
  function automatic logic [CNT_MAXW-1:0] cnt_next(input logic                rst_l,
                                                   input logic                load,
                                                   input logic [CNT_MAXW-1:0] ldata,
                                                   input logic [CNT_MAXW-1:0] cur,
                                                   input int unsigned         width);
    logic [CNT_MAXW-1:0] mask;
    logic [CNT_MAXW-1:0] res;
    mask = {CNT_MAXW{1'b1}} >> (CNT_MAXW - width);
    if (!rst_l) begin
      res = '0;
    end else if (load) begin
      res = ldata;
    end else begin
      res = cur + CNT_MAXW'(1);
    end
    return res & mask;
  endfunction

endpackage

// File: rtl/count_chk_err_log.sv
// Saturating mismatch counter, one-cycle mismatch pulse and first-error capture.
// A clear wins over a same-cycle hit for the count and log, but the pulse still fires.
module count_chk_err_log
  import count_chk_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ERRW  = ERRW_DEF
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             clr_i,
  input  logic             hit_i,
  input  logic [WIDTH-1:0] exp_i,
  input  logic [WIDTH-1:0] got_i,
  output logic             mismatch_o,
  output logic [ERRW-1:0]  err_count_o,
  output logic             first_valid_o,
  output logic [WIDTH-1:0] first_exp_o,
  output logic [WIDTH-1:0] first_got_o
);

  localparam logic [ERRW-1:0] Sat = ERRW'(ERR_SAT);

  logic             mis_q, mis_d;
  logic [ERRW-1:0]  cnt_q, cnt_d;
  logic             fv_q, fv_d;
  logic [WIDTH-1:0] fexp_q, fexp_d;
  logic [WIDTH-1:0] fgot_q, fgot_d;

  always_comb begin
    mis_d  = hit_i;
    cnt_d  = cnt_q;
    fv_d   = fv_q;
    fexp_d = fexp_q;
    fgot_d = fgot_q;
    if (clr_i) begin
      cnt_d  = '0;
      fv_d   = 1'b0;
      fexp_d = '0;
      fgot_d = '0;
    end else if (hit_i) begin
      if (cnt_q != Sat) begin
        cnt_d = cnt_q + ERRW'(1);
      end
      if (!fv_q) begin
        fv_d   = 1'b1;
        fexp_d = exp_i;
        fgot_d = got_i;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      mis_q  <= 1'b0;
      cnt_q  <= '0;
      fv_q   <= 1'b0;
      fexp_q <= '0;
      fgot_q <= '0;
    end else begin
      mis_q  <= mis_d;
      cnt_q  <= cnt_d;
      fv_q   <= fv_d;
      fexp_q <= fexp_d;
      fgot_q <= fgot_d;
    end
  end

  assign mismatch_o    = mis_q;
  assign err_count_o   = cnt_q;
  assign first_valid_o = fv_q;
  assign first_exp_o   = fexp_q;
  assign first_got_o   = fgot_q;

endmodule

// File: rtl/count_stream_checker.sv
// Passive checker for a loadable up-counter stream: predicts the next output from the
// observed controls, compares it against what the counter actually produces, and logs errors.
module count_stream_checker
  import count_chk_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ERRW   = ERRW_DEF,
  parameter bit          RESYNC = 1'b1
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             enable,
  input  logic             clr_err,
  input  logic             obs_rst_l,
  input  logic             obs_load,
  input  logic [WIDTH-1:0] obs_ldata,
  input  logic [WIDTH-1:0] obs_data,
  output logic             locked,
  output logic             mismatch,
  output logic [ERRW-1:0]  err_count,
  output logic             first_valid,
  output logic [WIDTH-1:0] first_exp,
  output logic [WIDTH-1:0] first_got
);

  chk_state_t       state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] nxt;
  logic             hit;

  // Prediction is always seeded from the observed value, so one error never cascades.
  assign nxt = WIDTH'(cnt_next(obs_rst_l, obs_load, CNT_MAXW'(obs_ldata),
                               CNT_MAXW'(obs_data), WIDTH));

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    hit     = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = SYNC;
        SYNC: begin
          exp_d   = nxt;
          state_d = TRACK;
        end
        TRACK: begin
          hit   = (obs_data != exp_q);
          exp_d = nxt;
          if (hit && !RESYNC) begin
            state_d = HALT;
          end
        end
        HALT: begin
          if (clr_err) begin
            state_d = SYNC;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= IDLE;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
    end
  end

  assign locked = (state_q == TRACK);

  count_chk_err_log #(
    .WIDTH (WIDTH),
    .ERRW  (ERRW)
  ) u_err_log (
    .clk           (clk),
    .reset_l       (reset_l),
    .clr_i         (clr_err),
    .hit_i         (hit),
    .exp_i         (exp_q),
    .got_i         (obs_data),
    .mismatch_o    (mismatch),
    .err_count_o   (err_count),
    .first_valid_o (first_valid),
    .first_exp_o   (first_exp),
    .first_got_o   (first_got)
  );

endmodule

// File: tb/tb_count_stream_checker.sv
// Directed bench for count_stream_checker: three instances (resync, halt-on-error, 2-bit count)
// share one observed stream; expected mismatch pulses go through a scoreboard queue.
module tb_count_stream_checker;

  logic       clk = 1'b0;
  logic       reset_l;
  logic       en_a, en_b, en_c, clr;
  logic       o_rst_l, o_load;
  logic [7:0] o_ldata, o_data;

  logic        lk_a, mis_a, fv_a, lk_b, mis_b, fv_b, lk_c, mis_c, fv_c;
  logic [15:0] err_a, err_b;
  logic [1:0]  err_c;
  logic [7:0]  fe_a, fg_a, fe_b, fg_b, fe_c, fg_c;

  int total = 0;
  int bad   = 0;
  int sel   = 0;
  bit sb[$];

  always #5 clk = ~clk;

  count_stream_checker #(.WIDTH(8), .ERRW(16), .RESYNC(1'b1)) dut_a (
    .clk(clk), .reset_l(reset_l), .enable(en_a), .clr_err(clr), .obs_rst_l(o_rst_l),
    .obs_load(o_load), .obs_ldata(o_ldata), .obs_data(o_data), .locked(lk_a),
    .mismatch(mis_a), .err_count(err_a), .first_valid(fv_a), .first_exp(fe_a),
    .first_got(fg_a));

  count_stream_checker #(.WIDTH(8), .ERRW(16), .RESYNC(1'b0)) dut_b (
    .clk(clk), .reset_l(reset_l), .enable(en_b), .clr_err(clr), .obs_rst_l(o_rst_l),
    .obs_load(o_load), .obs_ldata(o_ldata), .obs_data(o_data), .locked(lk_b),
    .mismatch(mis_b), .err_count(err_b), .first_valid(fv_b), .first_exp(fe_b),
    .first_got(fg_b));

  count_stream_checker #(.WIDTH(8), .ERRW(2), .RESYNC(1'b1)) dut_c (
    .clk(clk), .reset_l(reset_l), .enable(en_c), .clr_err(clr), .obs_rst_l(o_rst_l),
    .obs_load(o_load), .obs_ldata(o_ldata), .obs_data(o_data), .locked(lk_c),
    .mismatch(mis_c), .err_count(err_c), .first_valid(fv_c), .first_exp(fe_c),
    .first_got(fg_c));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    assert (got === expv) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, expv);
    end
  endtask

  function automatic logic mis_of(input int s);
    case (s)
      0:       return mis_a;
      1:       return mis_b;
      default: return mis_c;
    endcase
  endfunction

  // Drive one counter sample, queue the expected pulse, compare it one edge later.
  task automatic step(input logic [7:0] d, input logic rl, input logic ld, input logic [7:0] ldat,
                      input bit exp_mis, input string tag);
    o_data  = d;
    o_rst_l = rl;
    o_load  = ld;
    o_ldata = ldat;
    sb.push_back(exp_mis);
    @(posedge clk);
    #1;
    chk(tag, 32'(mis_of(sel)), 32'(sb.pop_front()));
  endtask

  initial begin
    logic [7:0] v;
    reset_l = 1'b0;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0; clr = 1'b0;
    o_rst_l = 1'b1; o_load = 1'b0; o_ldata = '0; o_data = '0;
    #12;
    chk("rst_locked", 32'(lk_a), 32'(0));
    chk("rst_mis",    32'(mis_a), 32'(0));
    chk("rst_err",    32'(err_a), 32'(0));
    chk("rst_fv",     32'(fv_a), 32'(0));
    reset_l = 1'b1;

    // Free-running stream across the FF->00 wrap.
    sel = 0; en_a = 1'b1;
    for (int i = 0; i < 12; i++) begin
      v = 8'hFA + 8'(i);
      step(v, 1'b1, 1'b0, 8'h00, 1'b0, "wrap_mis");
      chk("wrap_locked", 32'(lk_a), 32'(i >= 1));
    end
    chk("wrap_err", 32'(err_a), 32'(0));

    // Load takes effect on the same edge.
    step(8'h06, 1'b1, 1'b1, 8'h3C, 1'b0, "load_mis0");
    step(8'h3C, 1'b1, 1'b0, 8'h00, 1'b0, "load_mis1");
    step(8'h3D, 1'b1, 1'b0, 8'h00, 1'b0, "load_mis2");

    // Single bad sample with resync.
    step(8'h3E, 1'b1, 1'b1, 8'h11, 1'b0, "err_pre0");
    step(8'h11, 1'b1, 1'b0, 8'h00, 1'b0, "err_pre1");
    step(8'h10, 1'b1, 1'b0, 8'h00, 1'b1, "err_hit");
    chk("err_cnt1", 32'(err_a), 32'(1));
    chk("err_fv",   32'(fv_a), 32'(1));
    chk("err_fexp", 32'(fe_a), 32'h12);
    chk("err_fgot", 32'(fg_a), 32'h10);
    step(8'h11, 1'b1, 1'b0, 8'h00, 1'b0, "err_resync");
    chk("err_cnt_hold", 32'(err_a), 32'(1));

    // Sync reset has priority over load.
    step(8'h12, 1'b0, 1'b1, 8'hAA, 1'b0, "prio_set");
    step(8'hAA, 1'b1, 1'b0, 8'h00, 1'b1, "prio_hit");
    chk("prio_cnt",  32'(err_a), 32'(2));
    chk("prio_fexp", 32'(fe_a), 32'h12);
    step(8'hAB, 1'b1, 1'b0, 8'h00, 1'b0, "prio_after");

    // Enable drop keeps the log.
    en_a = 1'b0;
    step(8'h77, 1'b1, 1'b0, 8'h00, 1'b0, "dis_mis");
    chk("dis_locked", 32'(lk_a), 32'(0));
    chk("dis_cnt",    32'(err_a), 32'(2));
    chk("dis_fv",     32'(fv_a), 32'(1));

    // Halt-on-error instance.
    sel = 1; en_b = 1'b1;
    step(8'h20, 1'b1, 1'b0, 8'h00, 1'b0, "halt_idle");
    step(8'h21, 1'b1, 1'b0, 8'h00, 1'b0, "halt_sync");
    chk("halt_lock0", 32'(lk_b), 32'(1));
    step(8'h22, 1'b1, 1'b0, 8'h00, 1'b0, "halt_ok");
    step(8'h99, 1'b1, 1'b0, 8'h00, 1'b1, "halt_hit");
    chk("halt_locked", 32'(lk_b), 32'(0));
    chk("halt_cnt",    32'(err_b), 32'(1));
    chk("halt_fexp",   32'(fe_b), 32'h23);
    chk("halt_fgot",   32'(fg_b), 32'h99);
    step(8'h55, 1'b1, 1'b0, 8'h00, 1'b0, "halt_ign0");
    step(8'h77, 1'b1, 1'b0, 8'h00, 1'b0, "halt_ign1");
    chk("halt_cnt_hold", 32'(err_b), 32'(1));
    clr = 1'b1;
    step(8'h50, 1'b1, 1'b0, 8'h00, 1'b0, "halt_clr");
    clr = 1'b0;
    chk("halt_clr_cnt", 32'(err_b), 32'(0));
    chk("halt_clr_fv",  32'(fv_b), 32'(0));
    chk("halt_clr_lk",  32'(lk_b), 32'(0));
    step(8'h60, 1'b1, 1'b0, 8'h00, 1'b0, "halt_resync");
    chk("halt_relock", 32'(lk_b), 32'(1));
    step(8'h61, 1'b1, 1'b0, 8'h00, 1'b0, "halt_track");
    en_b = 1'b0;

    // Two-bit saturating counter and clear-vs-hit.
    sel = 2; en_c = 1'b1;
    step(8'h00, 1'b1, 1'b0, 8'h00, 1'b0, "sat_idle");
    step(8'h01, 1'b1, 1'b0, 8'h00, 1'b0, "sat_sync");
    for (int k = 1; k <= 5; k++) begin
      v = 8'(k * 16);
      step(v, 1'b1, 1'b0, 8'h00, 1'b1, "sat_hit");
      chk("sat_cnt", 32'(err_c), 32'((k > 3) ? 3 : k));
      if (k == 1) begin
        chk("sat_fexp", 32'(fe_c), 32'h02);
        chk("sat_fgot", 32'(fg_c), 32'h10);
      end
    end
    clr = 1'b1;
    step(8'h60, 1'b1, 1'b0, 8'h00, 1'b1, "clr_hit_pulse");
    clr = 1'b0;
    chk("clr_hit_cnt", 32'(err_c), 32'(0));
    chk("clr_hit_fv",  32'(fv_c), 32'(0));
    step(8'h61, 1'b1, 1'b0, 8'h00, 1'b0, "clr_after");
    step(8'h99, 1'b1, 1'b0, 8'h00, 1'b1, "pre_rst_hit");
    chk("pre_rst_cnt", 32'(err_c), 32'(1));

    // Asynchronous reset mid-track.
    #2 reset_l = 1'b0;
    #1;
    chk("arst_locked", 32'(lk_c), 32'(0));
    chk("arst_mis",    32'(mis_c), 32'(0));
    chk("arst_cnt",    32'(err_c), 32'(0));
    chk("arst_fv",     32'(fv_c), 32'(0));
    chk("arst_fgot",   32'(fg_c), 32'(0));
    #2 reset_l = 1'b1;
    step(8'h05, 1'b1, 1'b0, 8'h00, 1'b0, "rearm_idle");
    step(8'h06, 1'b1, 1'b0, 8'h00, 1'b0, "rearm_sync");
    step(8'h07, 1'b1, 1'b0, 8'h00, 1'b0, "rearm_track");
    chk("rearm_locked", 32'(lk_c), 32'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
